// File: rtl/puzzle_loader.sv
// puzzle_loader: sequences a new-game load. On start it registers the
// requested difficulty, waits one cycle for the map selector to settle,
// snapshots the selector outputs, then streams all CELLS cells into board
// storage over a valid/ready write port. It pulses done once the last cell
// has been accepted.
//
// Optional build macro: PUZZLE_LOADER_NO_REPEAT_EN
//   When defined, a sample whose index equals the most recently loaded
//   index is rejected and re-taken on the next cycle. After MAX_RETRY
//   rejections the current sample is accepted anyway.
//
// state_dbg exposes the FSM state for debug and checker binding.
module puzzle_loader #(
    parameter int CELLS     = 81,
    parameter int VAL_W     = 4,
    parameter int VIS_W     = 2,
    parameter int IDX_W     = 5,
    parameter int MAX_RETRY = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   difficulty_in,
    output logic                   difficulty,
    input  logic [CELLS*VAL_W-1:0] sel_map,
    input  logic [CELLS*VIS_W-1:0] sel_visibility,
    input  logic [IDX_W-1:0]       sel_index,
    output logic                   cell_valid,
    input  logic                   cell_ready,
    output logic [6:0]             cell_addr,
    output logic [VAL_W-1:0]       cell_value,
    output logic [VIS_W-1:0]       cell_vis,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       loaded_index,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SAMPLE = 3'd2,
        STREAM = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [6:0] LAST_ADDR = 7'(CELLS - 1);

    state_t state;
    state_t state_next;

    logic [CELLS*VAL_W-1:0] snapshot_map;
    logic [CELLS*VIS_W-1:0] snapshot_vis;
    logic [IDX_W-1:0]       snapshot_index;
    logic                   accept;

    // Write port handshake: a cell moves when cell_valid & cell_ready are both
    // high at a rising edge. While cell_valid is high and cell_ready is low,
    // cell_addr, cell_value and cell_vis are held unchanged; cell_valid never
    // drops until the presented cell has been accepted.
    logic transfer;
    assign transfer = cell_valid & cell_ready;

    // Cell data comes only from the snapshot, never from the live selector.
    assign cell_value = snapshot_map[int'(cell_addr)*VAL_W +: VAL_W];
    assign cell_vis   = snapshot_vis[int'(cell_addr)*VIS_W +: VIS_W];
    assign state_dbg  = state;

`ifdef PUZZLE_LOADER_NO_REPEAT_EN
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    logic [3:0] retry_cnt;

    // Accept a fresh index, or give up rejecting once the retry budget is spent.
    always_comb begin
        accept = (sel_index != loaded_index) || (retry_cnt == RETRY_LIMIT);
    end

    // Retry counter: cleared when a new load begins, counts rejected samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_cnt <= '0;
        end else if (state == IDLE && start) begin
            retry_cnt <= '0;
        end else if (state == SAMPLE && !accept) begin
            retry_cnt <= retry_cnt + 4'd1;
        end
    end
`else
    // Without repeat suppression the first sample is always taken.
    always_comb begin
        accept = 1'b1;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == FINISH);
        cell_valid = (state == STREAM);
        case (state)
            IDLE:    if (start) state_next = SELECT;
            SELECT:  state_next = SAMPLE;
            SAMPLE:  if (accept) state_next = STREAM;
            STREAM:  if (transfer && cell_addr == LAST_ADDR) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: difficulty latch, selector snapshot, address walk, loaded index.
    always_ff @(posedge clk) begin
        if (reset) begin
            difficulty     <= 1'b0;
            cell_addr      <= '0;
            snapshot_map   <= '0;
            snapshot_vis   <= '0;
            snapshot_index <= '0;
            loaded_index   <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) difficulty <= difficulty_in;
                end
                SAMPLE: begin
                    snapshot_map   <= sel_map;
                    snapshot_vis   <= sel_visibility;
                    snapshot_index <= sel_index;
                    cell_addr      <= '0;
                end
                STREAM: begin
                    if (transfer) begin
                        if (cell_addr == LAST_ADDR) begin
                            loaded_index <= snapshot_index;
                        end else begin
                            cell_addr <= cell_addr + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puzzle_loader.sv
// Directed bench for puzzle_loader: reset state, full loads with free-running
// and stalling ready, selector changes during streaming, start ignored while
// busy, reset abandoning a load, and (when the repeat-suppression macro is
// defined) rejection/retry behaviour.
module tb_puzzle_loader;

    localparam int CELLS = 81;
    localparam int VAL_W = 4;
    localparam int VIS_W = 2;
    localparam int IDX_W = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                   start = 1'b0;
    logic                   difficulty_in = 1'b0;
    logic                   difficulty;
    logic [CELLS*VAL_W-1:0] sel_map = '0;
    logic [CELLS*VIS_W-1:0] sel_visibility = '0;
    logic [IDX_W-1:0]       sel_index = '0;
    logic                   cell_valid;
    logic                   cell_ready = 1'b0;
    logic [6:0]             cell_addr;
    logic [VAL_W-1:0]       cell_value;
    logic [VIS_W-1:0]       cell_vis;
    logic                   busy;
    logic                   done;
    logic [IDX_W-1:0]       loaded_index;
    logic [2:0]             state_dbg;

    puzzle_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .difficulty_in  (difficulty_in),
        .difficulty     (difficulty),
        .sel_map        (sel_map),
        .sel_visibility (sel_visibility),
        .sel_index      (sel_index),
        .cell_valid     (cell_valid),
        .cell_ready     (cell_ready),
        .cell_addr      (cell_addr),
        .cell_value     (cell_value),
        .cell_vis       (cell_vis),
        .busy           (busy),
        .done           (done),
        .loaded_index   (loaded_index),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [VIS_W+VAL_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // ---------------- selector model ----------------
    function automatic logic [VAL_W-1:0] val_of(input int i, input logic [IDX_W-1:0] idx);
        return 4'(i * 5 + int'(idx));
    endfunction

    function automatic logic [VIS_W-1:0] vis_of(input int i, input logic [IDX_W-1:0] idx);
        return 2'((i >> 1) + int'(idx));
    endfunction

    task automatic fill_selector(input logic [IDX_W-1:0] idx);
        for (int i = 0; i < CELLS; i++) begin
            sel_map[i*VAL_W +: VAL_W]        = val_of(i, idx);
            sel_visibility[i*VIS_W +: VIS_W] = vis_of(i, idx);
        end
    endtask

    task automatic scramble_selector();
        for (int i = 0; i < CELLS; i++) begin
            sel_map[i*VAL_W +: VAL_W]        = 4'($urandom_range(0, 15));
            sel_visibility[i*VIS_W +: VIS_W] = 2'($urandom_range(0, 3));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full load. The selector presents rej_idx for the first n_rej
    // samples, then idx. Cycle 0 is the cycle in which start is high.
    task automatic run_load(input logic diff, input logic [IDX_W-1:0] idx,
                            input logic [IDX_W-1:0] rej_idx, input int n_rej,
                            input bit stall, input bit scramble);
        int cyc;
        int xfers;
        int first_valid;
        int done_cyc;
        bit prev_stall;
        logic [6:0] prev_addr;
        logic [VAL_W-1:0] prev_val;
        logic [VIS_W-1:0] prev_vis;
        logic [VIS_W+VAL_W-1:0] exp_e;
        logic [3:0] ready_pat;
        ready_pat = 4'b1001;

        fill_selector(idx);
        for (int i = 0; i < CELLS; i++) exp_q.push_back({vis_of(i, idx), val_of(i, idx)});
        sel_index = (n_rej > 0) ? rej_idx : idx;
        difficulty_in = diff;
        cell_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        difficulty_in = ~diff;
        cyc = 1;
        check("difficulty_latched", 32'(difficulty), 32'(diff));
        check("busy_after_start", 32'(busy), 32'd1);

        xfers = 0;
        first_valid = -1;
        done_cyc = -1;
        prev_stall = 1'b0;
        prev_addr = '0;
        prev_val = '0;
        prev_vis = '0;
        while (cyc < 400) begin
            sel_index = (cyc < 2 + n_rej) ? rej_idx : idx;
            if (scramble && cyc >= 3 + n_rej) scramble_selector();
            cell_ready = stall ? ready_pat[cyc % 4] : 1'b1;
            if (prev_stall) begin
                check("stall_hold_valid", 32'(cell_valid), 32'd1);
                check("stall_hold_addr", 32'(cell_addr), 32'(prev_addr));
                check("stall_hold_value", 32'(cell_value), 32'(prev_val));
                check("stall_hold_vis", 32'(cell_vis), 32'(prev_vis));
            end
            if (cell_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (cell_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_transfer", 32'(cell_addr), 32'hFFFF_FFFF);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("cell_addr", 32'(cell_addr), 32'(xfers));
                        check("cell_value", 32'(cell_value), 32'(exp_e[VAL_W-1:0]));
                        check("cell_vis", 32'(cell_vis), 32'(exp_e[VIS_W+VAL_W-1:VAL_W]));
                    end
                    xfers++;
                end
                prev_stall = !cell_ready;
                prev_addr  = cell_addr;
                prev_val   = cell_value;
                prev_vis   = cell_vis;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                check("loaded_index_at_done", 32'(loaded_index), 32'(idx));
                check("valid_low_at_done", 32'(cell_valid), 32'd0);
                break;
            end
            tick();
            cyc++;
        end

        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        check("transfer_count", 32'(xfers), 32'(CELLS));
        check("first_valid_cycle", 32'(first_valid), 32'(3 + n_rej));
        if (!stall) check("done_cycle", 32'(done_cyc), 32'(CELLS + 3 + n_rej));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_low_after", 32'(busy), 32'd0);
        check("state_idle_after", 32'(state_dbg), 32'd0);
        check("loaded_index_after", 32'(loaded_index), 32'(idx));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int guard;
        int done_count;

        // Reset, then idle.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_difficulty", 32'(difficulty), 32'd0);
        check("rst_valid", 32'(cell_valid), 32'd0);
        check("rst_addr", 32'(cell_addr), 32'd0);
        check("rst_value", 32'(cell_value), 32'd0);
        check("rst_vis", 32'(cell_vis), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_loaded_index", 32'(loaded_index), 32'h1F);

        // Plain load, ready tied high.
        run_load(1'b1, 5'd17, 5'd17, 0, 1'b0, 1'b0);
        // Stalling ready pattern 1,0,0,1.
        run_load(1'b0, 5'd5, 5'd5, 0, 1'b1, 1'b0);
        // Selector changes every cycle during streaming.
        run_load(1'b1, 5'd22, 5'd22, 0, 1'b0, 1'b1);

        // start ignored mid-stream, then reset abandons the load.
        done_count = 0;
        fill_selector(5'd9);
        sel_index = 5'd9;
        cell_ready = 1'b1;
        difficulty_in = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(cell_valid && cell_addr == 7'd40) && guard < 200) begin
            if (done) done_count++;
            tick();
            guard++;
        end
        check("reach_addr40", 32'(guard < 200), 32'd1);
        difficulty_in = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_difficulty", 32'(difficulty), 32'd1);
        check("start_ignored_state", 32'(state_dbg), 32'd3);
        check("start_ignored_addr", 32'(cell_addr), 32'd41);
        guard = 0;
        while (!(cell_valid && cell_addr == 7'd50) && guard < 200) begin
            if (done) done_count++;
            tick();
            guard++;
        end
        check("reach_addr50", 32'(guard < 200), 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_state", 32'(state_dbg), 32'd0);
        check("midrst_valid", 32'(cell_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(cell_addr), 32'd0);
        check("midrst_difficulty", 32'(difficulty), 32'd0);
        check("midrst_loaded_index", 32'(loaded_index), 32'h1F);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) done_count++;
            tick();
        end
        check("midrst_no_done", 32'(done_count), 32'd0);
        check("midrst_idle_after", 32'(state_dbg), 32'd0);

`ifdef PUZZLE_LOADER_NO_REPEAT_EN
        // Previous index 3; selector shows 3,3 then 8 -> two rejections.
        run_load(1'b0, 5'd3, 5'd3, 0, 1'b0, 1'b0);
        run_load(1'b1, 5'd8, 5'd3, 2, 1'b0, 1'b0);
        // Load 3 again, then selector stuck at 3 -> accepted after 15 retries.
        run_load(1'b0, 5'd3, 5'd3, 0, 1'b0, 1'b0);
        run_load(1'b1, 5'd3, 5'd3, 15, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
